seven_seg_scan_driver: RTL and testbench
========================================

Name: seven_seg_scan_driver

Overview:
- Parametrised multi-digit, time-multiplexed 7-segment display driver for the FRANK6000 board I/O.
- Latches a packed hex value and scans one digit per slot, with a blanking gap between digits to prevent ghosting.
- Supports per-digit decimal points, leading-zero suppression and configurable segment/digit polarity.
- Sits between the processor output register and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits; legal range 1..8.
- CLKS_PER_DIGIT, 25000, cycles a digit is lit per slot; minimum 1.
- BLANK_GAP, 2, cycles all digits are off before each lit period; 0 is legal and means no gap.
- SEG_ACTIVE_HIGH, 1, 1 means segment/dp lit = logic 1.
- DIG_ACTIVE_HIGH, 0, 1 means digit enable = logic 1.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_value  in  4*NUM_DIGITS  packed hex nibbles; nibble k drives digit k; digit 0 is rightmost/least significant.
- i_load  in  1  capture i_value and i_dp into the pending register this cycle.
- i_dp  in  NUM_DIGITS  decimal point per digit.
- i_lz_suppress  in  1  enable leading-zero blanking.
- i_enable  in  1  scan enable.
- o_seg  out  7  segments; bit6=A, bit5=B, bit4=C, bit3=D, bit2=E, bit1=F, bit0=G.
- o_dp  out  1  decimal point of the active digit.
- o_digit  out  NUM_DIGITS  one-hot digit select.
- o_frame_start  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- All outputs are registered.
- "Off" means: o_seg, o_dp at inactive segment level; o_digit all at inactive digit level.
- Reset (async, i_rst_n=0):
  - pending and display registers cleared to 0, pending dp cleared, digit index = 0, slot counter = 0.
  - FSM enters IDLE; outputs off; o_frame_start = 0.
  - Deasserting reset mid-frame restarts from IDLE with no partial slot.
- Font, active-high form, applied before polarity:
  - 0:7E, 1:30, 2:6D, 3:79, 4:33, 5:5B, 6:5F, 7:70
  - 8:7F, 9:7B, A:77, b:1F, C:4E, d:3D, E:4F, F:47
  - SEG_ACTIVE_HIGH=0 inverts o_seg and o_dp.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: outputs off, index 0. Go to BLANK when i_enable=1.
  - BLANK: lasts BLANK_GAP cycles, outputs off. If BLANK_GAP=0, BLANK is skipped and SHOW is entered directly.
  - SHOW: lasts CLKS_PER_DIGIT cycles. o_digit asserts bit[index] only; o_seg/o_dp show digit index. On expiry, index = (index+1) mod NUM_DIGITS, then go to BLANK.
  - Wrap: after index NUM_DIGITS-1, index returns to 0.
  - Slot length = BLANK_GAP + CLKS_PER_DIGIT; frame length = NUM_DIGITS × slot length.
- Frame start (first cycle of index 0's BLANK, or of its SHOW if BLANK_GAP=0):
  - o_frame_start = 1 for exactly that cycle.
  - Display registers load from the pending registers; i_load in the same cycle bypasses, so i_value/i_dp are used directly.
  - Mid-frame i_load never changes the frame in progress (no tearing).
- Leading-zero suppression (i_lz_suppress=1):
  - Digit k is blanked (segments off) if display nibbles k..NUM_DIGITS-1 are all zero and k>0.
  - Digit 0 is never suppressed.
  - Its dp still follows i_dp, and o_digit still asserts.
  - Evaluated on the display register; i_lz_suppress is sampled live.
- i_enable=0 in any state: next cycle IDLE, outputs off, index 0, counters cleared. Re-enable starts a fresh frame with o_frame_start.
- The slot counter must be wide enough for max(CLKS_PER_DIGIT, BLANK_GAP); no overflow.

Test Plan:
All scenarios use NUM_DIGITS=4, CLKS_PER_DIGIT=4, BLANK_GAP=1, SEG_ACTIVE_HIGH=1, DIG_ACTIVE_HIGH=0 (slot=5, frame=20).
- Reset: i_rst_n=0 mid-SHOW -> same cycle, o_seg=7'h00, o_dp=0, o_digit=4'b1111, o_frame_start=0; after release and i_enable=1, the first o_frame_start occurs 1 cycle later.
- Scan: load i_value=16'h12AF, i_dp=0 -> SHOW sequence o_digit=1110/1101/1011/0111 with o_seg=47,77,6D,30; each lit 4 cycles, separated by 1 blank cycle (o_digit=1111); o_frame_start period = 20 cycles.
- Tear-free load: i_value=16'h0000 on display, then i_load with 16'h8888 during the digit-2 slot -> current frame finishes showing 7E; the next frame shows 7F on all digits.
- Leading zeros: i_value=16'h0050, i_lz_suppress=1, i_dp=4'b1000 -> digit3 shows o_seg=00 with o_dp=1; digit2 shows 00; digit1 shows 5B; digit0 shows 7E.
- Disable/wrap: drop i_enable during the digit-2 SHOW -> next cycle all off; re-enable -> o_frame_start pulses and digit 0 is shown, not digit 3.
- Polarity: SEG_ACTIVE_HIGH=0, DIG_ACTIVE_HIGH=1, digit0 nibble 4'h1 -> while digit 0 is lit, o_seg=7'h4F and o_digit=4'b0001; during blank cycles, o_seg=7'h7F and o_digit=4'b0000.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - time-multiplexed multi-digit 7-segment scan driver
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS      = 4,
  parameter int CLKS_PER_DIGIT  = 25000,
  parameter int BLANK_GAP       = 2,
  parameter int SEG_ACTIVE_HIGH = 1,
  parameter int DIG_ACTIVE_HIGH = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_lz_suppress,
  input  logic                    i_enable,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_digit,
  output logic                    o_frame_start
);

  localparam int CNT_MAX = (CLKS_PER_DIGIT > BLANK_GAP) ? CLKS_PER_DIGIT : BLANK_GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_GAP > 0) ? BLANK_GAP - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_HIGH != 0) ? 7'h00 : 7'h7F;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_HIGH == 0);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_HIGH != 0) ? {NUM_DIGITS{1'b0}}
                                                                     : {NUM_DIGITS{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_e;

  // With no blanking gap a slot begins directly in SHOW.
  localparam state_e SLOT_FIRST = (BLANK_GAP > 0) ? S_BLANK : S_SHOW;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    fs_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] digit_q, digit_d;
  logic                  fs_q;

  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  lz_run;
  logic [3:0]            nibble;
  logic [6:0]            seg_raw;
  logic [NUM_DIGITS-1:0] digit_raw;
  logic                  dp_raw;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h7E;
      4'h1: font = 7'h30;
      4'h2: font = 7'h6D;
      4'h3: font = 7'h79;
      4'h4: font = 7'h33;
      4'h5: font = 7'h5B;
      4'h6: font = 7'h5F;
      4'h7: font = 7'h70;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h7B;
      4'hA: font = 7'h77;
      4'hB: font = 7'h1F;
      4'hC: font = 7'h4E;
      4'hD: font = 7'h3D;
      4'hE: font = 7'h4F;
      default: font = 7'h47;
    endcase
  endfunction

  // Scan sequencer: slot counter, digit index and frame-start detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fs_d    = 1'b0;
    if (!i_enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = SLOT_FIRST;
          cnt_d   = '0;
          idx_d   = '0;
          fs_d    = 1'b1;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = SLOT_FIRST;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            fs_d    = (idx_q == IDX_LAST);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Pending capture; display snapshot only at frame start so a frame never tears.
  always_comb begin
    pend_val_d = i_load ? i_value : pend_val_q;
    pend_dp_d  = i_load ? i_dp    : pend_dp_q;
    disp_val_d = fs_d ? pend_val_d : disp_val_q;
    disp_dp_d  = fs_d ? pend_dp_d  : disp_dp_q;
  end

  // Leading-zero mask: digit k blanks when it and every higher nibble are zero.
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_run     = lz_run & (disp_val_d[k*4 +: 4] == 4'h0);
      lz_mask[k] = lz_run & (k > 0);
    end
  end

  // Output decode from next-state values so the registered pins line up with the state.
  always_comb begin
    nibble    = disp_val_d[{idx_d, 2'b00} +: 4];
    seg_raw   = 7'h00;
    dp_raw    = 1'b0;
    digit_raw = '0;
    if (state_d == S_SHOW) begin
      seg_raw          = (i_lz_suppress && lz_mask[idx_d]) ? 7'h00 : font(nibble);
      dp_raw           = disp_dp_d[idx_d];
      digit_raw[idx_d] = 1'b1;
    end
    seg_d   = (SEG_ACTIVE_HIGH != 0) ? seg_raw : ~seg_raw;
    dp_d    = (SEG_ACTIVE_HIGH != 0) ? dp_raw  : ~dp_raw;
    digit_d = (DIG_ACTIVE_HIGH != 0) ? digit_raw : ~digit_raw;
  end

  // State, data and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      digit_q    <= DIG_OFF;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      digit_q    <= digit_d;
      fs_q       <= fs_d;
    end
  end

  assign o_seg         = seg_q;
  assign o_dp          = dp_q;
  assign o_digit       = digit_q;
  assign o_frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - directed self-checking bench for seven_seg_scan_driver
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_value;
  logic        i_load;
  logic [3:0]  i_dp;
  logic        i_lz;
  logic        i_en;

  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_digit;
  logic        o_fs;

  logic [15:0] value2 = 16'h0001;
  logic [3:0]  dp2    = 4'b0000;
  logic        lz2    = 1'b0;
  logic [6:0]  seg2;
  logic        dp2_o;
  logic [3:0]  digit2;
  logic        fs2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .CLKS_PER_DIGIT(4), .BLANK_GAP(1),
    .SEG_ACTIVE_HIGH(1), .DIG_ACTIVE_HIGH(0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(i_value), .i_load(i_load),
    .i_dp(i_dp), .i_lz_suppress(i_lz), .i_enable(i_en),
    .o_seg(o_seg), .o_dp(o_dp), .o_digit(o_digit), .o_frame_start(o_fs)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .CLKS_PER_DIGIT(4), .BLANK_GAP(1),
    .SEG_ACTIVE_HIGH(0), .DIG_ACTIVE_HIGH(1)
  ) dut_pol (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value2), .i_load(i_load),
    .i_dp(dp2), .i_lz_suppress(lz2), .i_enable(i_en),
    .o_seg(seg2), .o_dp(dp2_o), .o_digit(digit2), .o_frame_start(fs2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_seg"}, o_seg, 7'h00);
    chk({tag, "_dp"}, o_dp, 1'b0);
    chk({tag, "_digit"}, o_digit, 4'b1111);
    chk({tag, "_fs"}, o_fs, 1'b0);
    chk({tag, "_pol_seg"}, seg2, 7'h7F);
    chk({tag, "_pol_digit"}, digit2, 4'b0000);
  endtask

  // One full frame; segs packs digit k's expected pattern at bits [7k+6:7k].
  task automatic run_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps,
                           input int ld_slot, input logic [15:0] ld_val, input logic [3:0] ld_dp);
    logic [3:0] exp_dig;
    for (int s = 0; s < 4; s++) begin
      if (s == ld_slot) begin
        i_value = ld_val;
        i_dp    = ld_dp;
        i_load  = 1'b1;
      end
      tick();
      i_load = 1'b0;
      chk({tag, "_fs"}, o_fs, (s == 0));
      chk({tag, "_blank_digit"}, o_digit, 4'b1111);
      chk({tag, "_blank_seg"}, o_seg, 7'h00);
      chk({tag, "_pol_blank_seg"}, seg2, 7'h7F);
      chk({tag, "_pol_blank_digit"}, digit2, 4'b0000);
      exp_dig = ~(4'b0001 << s);
      for (int c = 0; c < 4; c++) begin
        tick();
        chk({tag, "_digit"}, o_digit, exp_dig);
        chk({tag, "_seg"}, o_seg, segs[s*7 +: 7]);
        chk({tag, "_dp"}, o_dp, dps[s]);
        chk({tag, "_fs_low"}, o_fs, 1'b0);
        if (s == 0) begin
          chk({tag, "_pol_seg"}, seg2, 7'h4F);
          chk({tag, "_pol_digit"}, digit2, 4'b0001);
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i_value = 16'h0000;
    i_load  = 1'b0;
    i_dp    = 4'b0000;
    i_lz    = 1'b0;
    i_en    = 1'b0;
    repeat (2) tick();
    chk_off("reset");
    rst_n = 1'b1;
    tick();
    chk_off("idle");

    i_value = 16'h12AF;
    i_dp    = 4'b0000;
    i_load  = 1'b1;
    tick();
    i_load = 1'b0;
    chk_off("idle_load");
    i_en = 1'b1;

    run_frame("scan", {7'h30, 7'h6D, 7'h77, 7'h47}, 4'b0000, 2, 16'h0000, 4'b0000);
    run_frame("zero", {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b0000, 2, 16'h8888, 4'b0000);
    i_lz = 1'b1;
    run_frame("eight", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b0000, 2, 16'h0050, 4'b1000);
    run_frame("lz", {7'h00, 7'h00, 7'h5B, 7'h7E}, 4'b1000, -1, 16'h0050, 4'b1000);

    repeat (11) tick();
    tick();
    chk("dis_pre_digit", o_digit, 4'b1011);
    chk("dis_pre_seg", o_seg, 7'h00);
    i_en = 1'b0;
    tick();
    chk_off("disabled");
    repeat (3) tick();
    chk_off("disabled_hold");
    i_en = 1'b1;
    run_frame("reen", {7'h00, 7'h00, 7'h5B, 7'h7E}, 4'b1000, -1, 16'h0050, 4'b1000);

    tick();
    tick();
    chk("rst_pre_digit", o_digit, 4'b1110);
    #2;
    rst_n = 1'b0;
    #1;
    chk_off("rst_async");
    tick();
    chk_off("rst_hold");
    i_lz  = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rst_fs", o_fs, 1'b1);
    chk("rst_fs_digit", o_digit, 4'b1111);
    tick();
    chk("rst_first_digit", o_digit, 4'b1110);
    chk("rst_first_seg", o_seg, 7'h7E);
    tick();
    chk("rst_fs_single", o_fs, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
